// File: rtl/ones_frame_accumulator.sv
// Sums the 2-bit per-group counts from the 3-input one-counter over a frame of
// GROUPS valid groups; publishes the frame total with a done pulse and threshold flag.
module ones_frame_accumulator #(
  parameter int GROUPS = 8,
  parameter int SW     = 5,
  parameter int THRESH = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          v,
  input  logic          y1,
  input  logic          y0,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] sum,
  output logic          over
);

  localparam logic [1:0]  IDLE     = 2'd0;
  localparam logic [1:0]  ACC      = 2'd1;
  localparam logic [1:0]  DONE     = 2'd2;
  localparam logic [7:0]  LAST     = 8'(GROUPS - 1);
  localparam logic [31:0] THRESH_U = 32'(THRESH);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] acc_q, acc_d;
  logic [SW-1:0] sum_q, sum_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          over_q, over_d;
  logic [SW-1:0] total;

  assign total = acc_q + SW'({y1, y0});

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    over_d  = over_q;
    // abort outranks start and v; the published result is left untouched
    if (abort) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ACC;
            acc_d   = '0;
            cnt_d   = '0;
          end
        end
        ACC: begin
          if (v) begin
            acc_d = total;
            cnt_d = cnt_q + 8'd1;
            if (cnt_q == LAST) begin
              sum_d   = total;
              over_d  = 32'(total) > THRESH_U;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = start ? ACC : IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      over_q  <= over_d;
    end
  end

  assign busy = (state_q == ACC);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign over = over_q;

endmodule
